// File: rtl/alu_datapath_seq.sv
// Operand-fetch / write-back sequencer around an external 16-bit ALU.
// Holds an 8x16 register file; one instruction every five cycles.
module alu_datapath_seq #(
  parameter int NREGS = 8,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   ra,
  input  logic [2:0]   rb,
  input  logic [2:0]   rd,
  input  logic [1:0]   op,
  input  logic [1:0]   shift,
  input  logic         asel,
  input  logic         bsel,
  input  logic [4:0]   imm5,
  input  logic         wb_en,
  input  logic         load,
  input  logic [2:0]   load_addr,
  input  logic [W-1:0] load_data,
  input  logic [W-1:0] alu_out,
  input  logic         alu_z,
  output logic [W-1:0] Ain,
  output logic [W-1:0] Bin,
  output logic [1:0]   ALUop,
  output logic [W-1:0] C,
  output logic         Z_out,
  output logic         busy,
  output logic         done,
  input  logic [2:0]   dbg_addr,
  output logic [W-1:0] dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_A,
    S_READ_B,
    S_EXEC,
    S_WRITE
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0] rf_q [NREGS];
  logic [W-1:0] a_q, b_q, c_q;
  logic         z_q, done_q;

  logic [2:0] ra_q, rb_q, rd_q;
  logic [1:0] op_q, shift_q;
  logic       asel_q, bsel_q, wb_en_q;
  logic [4:0] imm5_q;

  logic [W-1:0] b_shift;

  // Next-state: a fixed five-step walk once start is accepted
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_READ_A;
      S_READ_A: state_d = S_READ_B;
      S_READ_B: state_d = S_EXEC;
      S_EXEC:   state_d = S_WRITE;
      S_WRITE:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // B-operand conditioning ahead of the immediate select
  always_comb begin
    b_shift = b_q;
    unique case (shift_q)
      2'b00: b_shift = b_q;
      2'b01: b_shift = {b_q[W-2:0], 1'b0};
      2'b10: b_shift = {1'b0, b_q[W-1:1]};
      2'b11: b_shift = {b_q[W-1], b_q[W-1:1]};
      default: b_shift = b_q;
    endcase
  end

  // State, instruction latch, operand/result registers and register file
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      op_q    <= '0;
      shift_q <= '0;
      asel_q  <= 1'b0;
      bsel_q  <= 1'b0;
      imm5_q  <= '0;
      wb_en_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_WRITE);
      if (state_q == S_IDLE && start) begin
        ra_q    <= ra;
        rb_q    <= rb;
        rd_q    <= rd;
        op_q    <= op;
        shift_q <= shift;
        asel_q  <= asel;
        bsel_q  <= bsel;
        imm5_q  <= imm5;
        wb_en_q <= wb_en;
      end
      if (state_q == S_READ_A) a_q <= rf_q[ra_q];
      if (state_q == S_READ_B) b_q <= rf_q[rb_q];
      if (state_q == S_EXEC) begin
        c_q <= alu_out;
        z_q <= alu_z;
      end
      // Later assignment wins: write-back overrides a same-address load
      if (load) rf_q[load_addr] <= load_data;
      if (state_q == S_WRITE && wb_en_q) rf_q[rd_q] <= c_q;
    end
  end

  assign Ain      = asel_q ? '0 : a_q;
  assign Bin      = bsel_q ? {{(W-5){1'b0}}, imm5_q} : b_shift;
  assign ALUop    = op_q;
  assign C        = c_q;
  assign Z_out    = z_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_datapath_seq.sv
// Self-checking bench for alu_datapath_seq with a behavioural ALU
// and a register-file reference model.
module tb_alu_datapath_seq;

  logic        clk = 1'b0;
  logic        reset, start, asel, bsel, wb_en, load;
  logic [2:0]  ra, rb, rd, load_addr, dbg_addr;
  logic [1:0]  op, shift, ALUop;
  logic [4:0]  imm5;
  logic [15:0] load_data, alu_out, Ain, Bin, C, dbg_data;
  logic        alu_z, Z_out, busy, done;

  int checks = 0;
  int errors = 0;

  int unsigned m_rf [8];
  int unsigned m_c;
  int unsigned m_z;

  always #5 clk = ~clk;

  alu_datapath_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .ra(ra), .rb(rb), .rd(rd), .op(op), .shift(shift),
    .asel(asel), .bsel(bsel), .imm5(imm5), .wb_en(wb_en),
    .load(load), .load_addr(load_addr), .load_data(load_data),
    .alu_out(alu_out), .alu_z(alu_z),
    .Ain(Ain), .Bin(Bin), .ALUop(ALUop), .C(C), .Z_out(Z_out),
    .busy(busy), .done(done),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // External combinational ALU
  always_comb begin
    alu_out = 16'h0;
    case (ALUop)
      2'b00: alu_out = Ain + Bin;
      2'b01: alu_out = Ain - Bin;
      2'b10: alu_out = Ain & Bin;
      default: alu_out = ~Bin;
    endcase
    alu_z = (alu_out == 16'h0);
  end

  function automatic int unsigned model_exec(
    int unsigned a_r, int unsigned b_r, int unsigned o,
    int unsigned sh, int unsigned as, int unsigned bs, int unsigned im);
    int unsigned a, b, r;
    a = as ? 0 : m_rf[a_r];
    b = m_rf[b_r];
    if (bs) b = im;
    else if (sh == 1) b = (b * 2) % 65536;
    else if (sh == 2) b = b / 2;
    else if (sh == 3) b = b / 2 + ((b >= 32768) ? 32768 : 0);
    if (o == 0) r = (a + b) % 65536;
    else if (o == 1) r = (a + 65536 - b) % 65536;
    else if (o == 2) r = a & b;
    else r = 65535 - b;
    return r;
  endfunction

  task automatic model_run(int unsigned a_r, int unsigned b_r,
    int unsigned d_r, int unsigned o, int unsigned sh, int unsigned as,
    int unsigned bs, int unsigned im, int unsigned we);
    m_c = model_exec(a_r, b_r, o, sh, as, bs, im);
    m_z = (m_c == 0) ? 1 : 0;
    if (we) m_rf[d_r] = m_c;
  endtask

  task automatic do_load(input logic [2:0] a, input logic [15:0] d);
    load = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load = 1'b0;
    m_rf[a] = d;
  endtask

  function automatic logic [15:0] rd_reg(input logic [2:0] a);
    return dut.rf_q[a];
  endfunction

  // hz: 0 none, 1 start during READ_B, 2 load rd during WRITE, 3 reset in EXEC
  task automatic issue(
    input logic [2:0] a_r, input logic [2:0] b_r, input logic [2:0] d_r,
    input logic [1:0] o, input logic [1:0] sh, input logic as,
    input logic bs, input logic [4:0] im, input logic we, input int hz,
    output int lat, output int ndone, output int aluop_bad);
    int n;
    ra = a_r; rb = b_r; rd = d_r; op = o; shift = sh;
    asel = as; bsel = bs; imm5 = im; wb_en = we;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 99; ndone = 0; aluop_bad = 0; n = 0;
    while (n < 10) begin
      if (hz == 1 && n == 1) begin
        start = 1'b1; rd = d_r + 3'd1; op = ~o; wb_en = 1'b1;
      end
      if (hz == 1 && n == 2) start = 1'b0;
      if (hz == 2 && n == 3) begin
        load = 1'b1; load_addr = d_r; load_data = 16'hDEAD;
      end
      if (hz == 3 && n == 2) reset = 1'b1;
      if (hz == 3 && n == 3) reset = 1'b0;
      @(posedge clk); #1;
      n++;
      if (ALUop !== o && hz != 3) aluop_bad = 1;
      if (done === 1'b1) begin
        ndone++;
        if (lat == 99) lat = n;
        if (hz == 0 || hz == 2) break;
      end
    end
    load = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dbg_addr = i[2:0]; #1;
      checks++;
      if (dbg_data !== 16'h0) begin
        errors++;
        $display("FAIL reset_reg%0d got %h want 0000", i, dbg_data);
      end
      m_rf[i] = 0;
    end
    m_c = 0; m_z = 0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || C !== 16'h0 ||
        Z_out !== 1'b0 || ALUop !== 2'b00) begin
      errors++;
      $display("FAIL reset_status got busy=%b done=%b C=%h Z=%b op=%b want 0",
               busy, done, C, Z_out, ALUop);
    end
  endtask

  task automatic test_add;
    int lat, nd, bad;
    do_load(3'd0, 16'h0007);
    do_load(3'd1, 16'h0005);
    issue(3'd0, 3'd1, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1, 0,
          lat, nd, bad);
    model_run(0, 1, 2, 0, 0, 0, 0, 0, 1);
    checks++;
    if (lat != 4) begin
      errors++; $display("FAIL add_latency got %0d want 4", lat);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL add_busy_in_done got %b want 0", busy);
    end
    dbg_addr = 3'd2; #1;
    checks++;
    if (dbg_data !== 16'h000C || Z_out !== 1'b0) begin
      errors++;
      $display("FAIL add_result got R2=%h Z=%b want 000c 0", dbg_data, Z_out);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL add_aluop got changed want 00 throughout");
    end
  endtask

  task automatic test_back_to_back;
    int lat, nd, bad;
    issue(3'd1, 3'd1, 3'd3, 2'b01, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1, 0,
          lat, nd, bad);
    model_run(1, 1, 3, 1, 0, 0, 0, 0, 1);
    dbg_addr = 3'd3; #1;
    checks++;
    if (dbg_data !== 16'h0000 || Z_out !== 1'b1) begin
      errors++;
      $display("FAIL sub_zero got R3=%h Z=%b want 0000 1", dbg_data, Z_out);
    end
    // issue() returns in the done cycle, so this start lands at E5
    issue(3'd0, 3'd1, 3'd4, 2'b01, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1, 0,
          lat, nd, bad);
    model_run(0, 1, 4, 1, 0, 0, 0, 0, 1);
    dbg_addr = 3'd4; #1;
    checks++;
    if (dbg_data !== 16'h0002 || Z_out !== 1'b0 || lat != 4) begin
      errors++;
      $display("FAIL sub_b2b got R4=%h Z=%b lat=%0d want 0002 0 4",
               dbg_data, Z_out, lat);
    end
  endtask

  task automatic test_shift_select;
    int lat, nd, bad;
    logic [15:0] exp [4];
    logic [1:0]  shs [4];
    exp[0] = 16'hC000; exp[1] = 16'h4000; exp[2] = 16'h0002; exp[3] = 16'h001F;
    shs[0] = 2'b11; shs[1] = 2'b10; shs[2] = 2'b01; shs[3] = 2'b00;
    do_load(3'd5, 16'h8001);
    for (int i = 0; i < 4; i++) begin
      issue(3'd0, 3'd5, 3'd6, 2'b00, shs[i], 1'b1, (i == 3), 5'h1F, 1'b1, 0,
            lat, nd, bad);
      model_run(0, 5, 6, 0, shs[i], 1, (i == 3), 31, 1);
      dbg_addr = 3'd6; #1;
      checks++;
      if (dbg_data !== exp[i] || C !== exp[i]) begin
        errors++;
        $display("FAIL shift_sel%0d got R6=%h C=%h want %h",
                 i, dbg_data, C, exp[i]);
      end
    end
  endtask

  task automatic test_busy_hazards;
    int lat, nd, bad;
    issue(3'd0, 3'd1, 3'd2, 2'b10, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1, 1,
          lat, nd, bad);
    model_run(0, 1, 2, 2, 0, 0, 0, 0, 1);
    dbg_addr = 3'd2; #1;
    checks++;
    if (nd != 1 || dbg_data !== m_rf[2][15:0] || dbg_data !== 16'h0005) begin
      errors++;
      $display("FAIL busy_ignore got dones=%0d R2=%h want 1 0005",
               nd, dbg_data);
    end
    checks++;
    if (rd_reg(3'd3) !== m_rf[3][15:0]) begin
      errors++;
      $display("FAIL busy_no_queue got R3=%h want %h", rd_reg(3'd3), m_rf[3]);
    end
    issue(3'd0, 3'd0, 3'd3, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1, 2,
          lat, nd, bad);
    model_run(0, 0, 3, 0, 0, 0, 0, 0, 1);
    dbg_addr = 3'd3; #1;
    checks++;
    if (dbg_data !== 16'h000E) begin
      errors++;
      $display("FAIL load_vs_wb got R3=%h want 000e", dbg_data);
    end
    issue(3'd0, 3'd5, 3'd1, 2'b11, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 0,
          lat, nd, bad);
    model_run(0, 5, 1, 3, 0, 0, 0, 0, 0);
    dbg_addr = 3'd1; #1;
    checks++;
    if (C !== 16'h7FFE || dbg_data !== 16'h0005) begin
      errors++;
      $display("FAIL notb_nowb got C=%h R1=%h want 7ffe 0005", C, dbg_data);
    end
  endtask

  task automatic test_reset_mid;
    int lat, nd, bad;
    issue(3'd0, 3'd1, 3'd7, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1, 3,
          lat, nd, bad);
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
    m_c = 0; m_z = 0;
    dbg_addr = 3'd7; #1;
    checks++;
    if (dbg_data !== 16'h0 || nd != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got R7=%h dones=%0d busy=%b want 0000 0 0",
               dbg_data, nd, busy);
    end
    do_load(3'd0, 16'h1234);
    do_load(3'd1, 16'h0101);
    issue(3'd0, 3'd1, 3'd7, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1, 0,
          lat, nd, bad);
    model_run(0, 1, 7, 0, 0, 0, 0, 0, 1);
    dbg_addr = 3'd7; #1;
    checks++;
    if (dbg_data !== 16'h1335 || lat != 4) begin
      errors++;
      $display("FAIL after_reset got R7=%h lat=%0d want 1335 4", dbg_data, lat);
    end
  endtask

  task automatic test_random;
    int lat, nd, bad;
    logic [2:0] a_r, b_r, d_r;
    logic [1:0] o, sh;
    logic as, bs, we;
    logic [4:0] im;
    for (int i = 0; i < 8; i++) do_load(i[2:0], 16'($urandom));
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0)
        do_load(3'($urandom), 16'($urandom));
      a_r = 3'($urandom); b_r = 3'($urandom); d_r = 3'($urandom);
      o = 2'($urandom); sh = 2'($urandom); im = 5'($urandom);
      as = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 3) == 0);
      we = ($urandom_range(0, 4) != 0);
      issue(a_r, b_r, d_r, o, sh, as, bs, im, we, 0, lat, nd, bad);
      model_run(a_r, b_r, d_r, o, sh, as, bs, im, we);
      dbg_addr = d_r; #1;
      checks++;
      if (C !== m_c[15:0] || Z_out !== m_z[0] ||
          dbg_data !== m_rf[d_r][15:0] || lat != 4 || bad != 0) begin
        errors++;
        $display("FAIL random%0d got C=%h Z=%b R%0d=%h lat=%0d want %h %0d %h 4",
                 t, C, Z_out, d_r, dbg_data, lat, m_c, m_z, m_rf[d_r]);
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; load = 1'b0;
    ra = '0; rb = '0; rd = '0; op = '0; shift = '0;
    asel = 1'b0; bsel = 1'b0; imm5 = '0; wb_en = 1'b0;
    load_addr = '0; load_data = '0; dbg_addr = '0;
    test_reset;
    test_add;
    test_back_to_back;
    test_shift_select;
    test_busy_hazards;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
